// File: rtl/ay8_bus_sequencer.sv
// ay8_bus_sequencer: memory-access front end of the AY8 CPU.
// Arbitrates between the instruction-fetch port (read only) and the data
// port (read/write), then runs one IDLE -> ISSUE -> XFER -> RESP transfer at
// a time onto the unified memory bus. If the memory never raises mem_busy
// within TIMEOUT transfer cycles, the access is acknowledged with bus_err set.

module ay8_bus_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_err,
    output logic              mem_start,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_busy,
    inout  wire  [DATA_W-1:0] uni_bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        RESP
    } state_t;

    state_t            state_q;
    logic              sel_data_q;
    logic              prefer_data_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              drive_q;
    logic              mem_start_q;
    logic              mem_rw_q;
    logic              f_ack_q;
    logic              d_ack_q;
    logic              bus_err_q;
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              grant_d;
    logic              grant_data_d;

    // Round-robin arbitration: a lone requester wins, on a tie the port not granted last wins.
    always_comb begin
        grant_d      = 1'b0;
        grant_data_d = 1'b0;
        if ((f_req || d_req) && !mem_busy) begin
            grant_d      = 1'b1;
            grant_data_d = d_req && (!f_req || prefer_data_q);
        end
    end

    // Transfer sequencer with registered memory strobes, acks and read-data capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            sel_data_q    <= 1'b0;
            prefer_data_q <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            drive_q       <= 1'b0;
            mem_start_q   <= 1'b0;
            mem_rw_q      <= 1'b0;
            f_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            bus_err_q     <= 1'b0;
            f_rdata_q     <= '0;
            d_rdata_q     <= '0;
        end else begin
            mem_start_q <= 1'b0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        sel_data_q    <= grant_data_d;
                        prefer_data_q <= !grant_data_d;
                        we_q          <= grant_data_d && d_we;
                        addr_q        <= grant_data_d ? d_addr : f_addr;
                        wdata_q       <= d_wdata;
                        mem_start_q   <= 1'b1;
                        mem_rw_q      <= !(grant_data_d && d_we);
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    drive_q <= we_q;
                    state_q <= XFER;
                end
                XFER: begin
                    if (mem_busy) begin
                        if (!we_q) begin
                            if (sel_data_q) begin
                                d_rdata_q <= uni_bus;
                            end else begin
                                f_rdata_q <= uni_bus;
                            end
                        end
                        drive_q <= 1'b0;
                        f_ack_q <= !sel_data_q;
                        d_ack_q <= sel_data_q;
                        state_q <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        if (!we_q) begin
                            if (sel_data_q) begin
                                d_rdata_q <= '1;
                            end else begin
                                f_rdata_q <= '1;
                            end
                        end
                        drive_q   <= 1'b0;
                        f_ack_q   <= !sel_data_q;
                        d_ack_q   <= sel_data_q;
                        bus_err_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    cnt_q   <= '0;
                    drive_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    drive_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign uni_bus   = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign mem_start = mem_start_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = addr_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign bus_err   = bus_err_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_ay8_bus_sequencer.sv
// tb_ay8_bus_sequencer: self-checking bench for ay8_bus_sequencer.
// A behavioural memory answers each mem_start after a chosen number of
// transfer cycles (or never), and a transaction-level model predicts grant
// order, ack latency, bus errors and read data from a reference memory image.

module tb_ay8_bus_sequencer;

    localparam int TIMEOUT = 4;

    logic       CLK;
    logic       RST;
    logic       f_req;
    logic [7:0] f_addr;
    logic       f_ack;
    logic [7:0] f_rdata;
    logic       d_req;
    logic       d_we;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_ack;
    logic [7:0] d_rdata;
    logic       bus_err;
    logic       mem_start;
    logic       mem_rw;
    logic [7:0] mem_addr;
    logic       mem_busy;
    wire  [7:0] uni_bus;

    int passCount;
    int checkCount;

    // Memory model state
    logic [7:0] memArr [256];
    logic       memBusyR;
    logic       memDrv;
    logic [7:0] memOut;
    logic       holdBusy;
    int         memLatency;
    bit         memActive;
    int         memK;
    logic       memRw;
    logic [7:0] memAddr;
    logic [7:0] lastAddr;
    logic       lastRw;
    logic [7:0] expWdata;

    // Transaction-level reference model state
    logic [7:0] refMem [256];
    bit         preferData;
    logic [7:0] fRdModel;
    logic [7:0] dRdModel;
    logic [7:0] curFAddr;
    logic [7:0] curDAddr;
    bit         curDWe;
    logic [7:0] curDWdata;
    logic [7:0] zBus;

    ay8_bus_sequencer #(
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_ack    (f_ack),
        .f_rdata  (f_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .bus_err  (bus_err),
        .mem_start(mem_start),
        .mem_rw   (mem_rw),
        .mem_addr (mem_addr),
        .mem_busy (mem_busy),
        .uni_bus  (uni_bus)
    );

    assign mem_busy = memBusyR | holdBusy;
    assign uni_bus  = memDrv ? memOut : 8'bz;

    // 100 MHz clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog so a stuck run still ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            passCount++;
        end
    endtask

    // Memory: answers memLatency XFER cycles after the strobe (0 = never answers)
    always @(posedge CLK) begin
        #1;
        memBusyR = 1'b0;
        memDrv   = 1'b0;
        if (RST) begin
            memActive = 1'b0;
        end else if (mem_start) begin
            memActive = 1'b1;
            memK      = 0;
            memRw     = mem_rw;
            memAddr   = mem_addr;
            lastAddr  = mem_addr;
            lastRw    = mem_rw;
        end else if (memActive) begin
            memK++;
            if (memLatency != 0 && memK == memLatency) begin
                memBusyR  = 1'b1;
                memActive = 1'b0;
                if (memRw) begin
                    memOut = memArr[memAddr];
                    memDrv = 1'b1;
                end else begin
                    checkOutput("busWrite", 32'(uni_bus), 32'(expWdata));
                    memArr[memAddr] = uni_bus;
                end
            end else if (memK >= TIMEOUT) begin
                memActive = 1'b0;
            end
        end
    end

    // Waits for each predicted grant's ack and checks it against the model
    task automatic runGrants(input bit fOn, input bit dOn, input int lat);
        bit order [2];
        int n;
        int xfer;
        xfer = (lat == 0) ? TIMEOUT : lat;
        if (fOn && dOn) begin
            order[0] = preferData;
            order[1] = !preferData;
            n = 2;
        end else begin
            order[0] = dOn;
            order[1] = 1'b0;
            n = 1;
        end
        expWdata = curDWdata;
        for (int g = 0; g < n; g++) begin
            bit         isData;
            bit         isWrite;
            logic [7:0] addr;
            logic [7:0] expRd;
            int         expWait;
            int         waited;
            bit         seen;
            isData     = order[g];
            isWrite    = isData && curDWe;
            addr       = isData ? curDAddr : curFAddr;
            expWait    = (g == 0) ? 2 + xfer : 3 + xfer;
            waited     = 0;
            seen       = 1'b0;
            preferData = !isData;
            while (!seen && waited < 40) begin
                @(posedge CLK);
                #1;
                waited++;
                if (f_ack || d_ack) begin
                    seen = 1'b1;
                end else if (!isWrite && !memDrv) begin
                    checkOutput("busIdleZ", 32'(uni_bus), 32'(zBus));
                end
            end
            checkOutput("ackSeen", 32'(seen), 32'd1);
            checkOutput("ackCycles", waited, expWait);
            checkOutput("fAck", 32'(f_ack), 32'(!isData));
            checkOutput("dAck", 32'(d_ack), 32'(isData));
            checkOutput("busErr", 32'(bus_err), 32'(lat == 0));
            checkOutput("grantAddr", 32'(lastAddr), 32'(addr));
            checkOutput("grantRw", 32'(lastRw), 32'(!isWrite));
            if (!isWrite) begin
                expRd = (lat == 0) ? 8'hFF : refMem[addr];
                if (isData) dRdModel = expRd;
                else        fRdModel = expRd;
            end else if (lat != 0) begin
                refMem[addr] = curDWdata;
            end
            checkOutput("fRdata", 32'(f_rdata), 32'(fRdModel));
            checkOutput("dRdata", 32'(d_rdata), 32'(dRdModel));
            if (isData) d_req = 1'b0;
            else        f_req = 1'b0;
        end
        @(posedge CLK);
        #1;
        checkOutput("ackPulse", 32'({f_ack, d_ack, bus_err}), 32'd0);
    endtask

    task automatic setReqs(input bit fOn, input bit dOn, input logic [7:0] fA, input logic [7:0] dA,
                           input bit dW, input logic [7:0] dWd, input int lat);
        f_req      = fOn;
        f_addr     = fA;
        d_req      = dOn;
        d_addr     = dA;
        d_we       = dW;
        d_wdata    = dWd;
        memLatency = lat;
        curFAddr   = fA;
        curDAddr   = dA;
        curDWe     = dW;
        curDWdata  = dWd;
    endtask

    task automatic applyStimulus(input bit fOn, input bit dOn, input logic [7:0] fA, input logic [7:0] dA,
                                 input bit dW, input logic [7:0] dWd, input int lat);
        @(negedge CLK);
        setReqs(fOn, dOn, fA, dA, dW, dWd, lat);
        runGrants(fOn, dOn, lat);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busZ"}, 32'(uni_bus), 32'(zBus));
        checkOutput({tag, "_outs"}, 32'({f_ack, d_ack, bus_err, mem_start, mem_rw}), 32'd0);
        checkOutput({tag, "_memAddr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_rdata"}, 32'({f_rdata, d_rdata}), 32'd0);
    endtask

    task automatic resetModel();
        preferData = 1'b1;
        fRdModel   = 8'h00;
        dRdModel   = 8'h00;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        zBus       = 8'bz;
        memBusyR   = 1'b0;
        memDrv     = 1'b0;
        memOut     = 8'h00;
        memActive  = 1'b0;
        memK       = 0;
        holdBusy   = 1'b0;
        lastAddr   = 8'h00;
        lastRw     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            memArr[i] = 8'($urandom);
            refMem[i] = memArr[i];
        end
        RST = 1'b1;
        setReqs(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1);
        resetModel();
        repeat (2) @(posedge CLK);
        #1;
        checkResetOutputs("reset");
        @(negedge CLK);
        RST = 1'b0;

        // Write then read back through the fetch port
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h10, 1'b1, 8'hA5, 1);
        applyStimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1);
        checkOutput("fetchReadA5", 32'(f_rdata), 32'h0000_00A5);

        // Both ports read together: data, fetch, data, fetch
        applyStimulus(1'b1, 1'b1, 8'h21, 8'h20, 1'b0, 8'h00, 1);
        applyStimulus(1'b1, 1'b1, 8'h22, 8'h20, 1'b0, 8'h00, 2);

        // Memory never answers: timeout with all-ones read data
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h30, 1'b0, 8'h00, 0);
        checkOutput("timeoutRdata", 32'(d_rdata), 32'h0000_00FF);

        // Reset in the middle of a write transfer abandons it; held request re-issues
        @(negedge CLK);
        setReqs(1'b0, 1'b1, 8'h00, 8'h40, 1'b1, 8'h5A, 2);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        checkOutput("midXferDrive", 32'(uni_bus), 32'h0000_005A);
        #1;
        RST = 1'b1;
        #1;
        checkResetOutputs("midReset");
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        resetModel();
        runGrants(1'b0, 1'b1, 2);

        // Memory busy in IDLE holds off the strobe
        @(negedge CLK);
        holdBusy = 1'b1;
        setReqs(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            checkOutput("busyNoStart", 32'(mem_start), 32'd0);
        end
        @(negedge CLK);
        holdBusy = 1'b0;
        runGrants(1'b1, 1'b0, 1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            bit fOn;
            bit dOn;
            int r;
            int lat;
            fOn = 1'($urandom);
            dOn = 1'($urandom);
            if (!fOn && !dOn) dOn = 1'b1;
            r   = int'($urandom_range(0, 9));
            lat = (r < 2) ? 0 : 1 + (r % 4);
            applyStimulus(fOn, dOn, 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), lat);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
